// File: rtl/pwm_regbank.sv
// Register bank and two-channel PWM generator fed by the SPI sampled slave.
// Period/duty writes land in staging registers and move into the active set
// only at a period boundary (or continuously while idle), so a running
// output never changes shape mid-period.
module pwm_regbank #(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr_reg,
  input  logic [7:0] data_wr,
  input  logic       wr_en,
  output logic [7:0] data_rd_o,
  output logic [1:0] pwm_out
);

  localparam int DATA_W = 8;

  localparam logic [6:0] A_CTRL     = 7'h00;
  localparam logic [6:0] A_PRESCALE = 7'h01;
  localparam logic [6:0] A_PERIOD   = 7'h02;
  localparam logic [6:0] A_DUTY0    = 7'h03;
  localparam logic [6:0] A_DUTY1    = 7'h04;
  localparam logic [6:0] A_STATUS   = 7'h05;
  localparam logic [6:0] A_ID       = 7'h06;
  localparam logic [6:0] A_COUNT    = 7'h07;

  logic [6:0]        reg_addr;
  logic              unused_addr_msb;

  logic [3:0]        ctrl_q;
  logic [DATA_W-1:0] prescale_q;
  logic [DATA_W-1:0] period_s, duty0_s, duty1_s;
  logic [DATA_W-1:0] period_a, duty0_a, duty1_a;
  logic [DATA_W-1:0] psc_q, cnt_q;
  logic              pend_q;

  logic              running, tick, wrap, load, stage_wr;
  logic [1:0]        raw_p0;
  logic [1:0]        pwm_p1;

  // Bit 7 of the SPI address is a read/write flag upstream; it has no meaning here.
  assign reg_addr        = addr_reg[6:0];
  assign unused_addr_msb = addr_reg[7];

  assign running  = ctrl_q[0] | ctrl_q[1];
  assign tick     = running && (psc_q == prescale_q);
  assign wrap     = tick && (cnt_q == period_a);
  assign load     = !running || wrap;
  assign stage_wr = wr_en && ((reg_addr == A_PERIOD) ||
                              (reg_addr == A_DUTY0)  ||
                              (reg_addr == A_DUTY1));

  // Software-visible registers: a held strobe simply rewrites the same value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= 4'h0;
      prescale_q <= 8'h00;
      period_s   <= 8'hFF;
      duty0_s    <= 8'h00;
      duty1_s    <= 8'h00;
    end else if (wr_en) begin
      case (reg_addr)
        A_CTRL:     ctrl_q     <= data_wr[3:0];
        A_PRESCALE: prescale_q <= data_wr;
        A_PERIOD:   period_s   <= data_wr;
        A_DUTY0:    duty0_s    <= data_wr;
        A_DUTY1:    duty1_s    <= data_wr;
        default:    ;
      endcase
    end
  end

  // Active set samples the pre-write staging values, so a write colliding with a load stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_a <= 8'hFF;
      duty0_a  <= 8'h00;
      duty1_a  <= 8'h00;
    end else if (load) begin
      period_a <= period_s;
      duty0_a  <= duty0_s;
      duty1_a  <= duty1_s;
    end
  end

  // Prescaler and period counter; both parked at 0 while both channels are off.
  // A prescaler already above a newly lowered PRESCALE runs on through 255 to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= 8'h00;
      cnt_q <= 8'h00;
    end else if (!running) begin
      psc_q <= 8'h00;
      cnt_q <= 8'h00;
    end else if (tick) begin
      psc_q <= 8'h00;
      cnt_q <= wrap ? 8'h00 : cnt_q + 8'd1;
    end else begin
      psc_q <= psc_q + 8'd1;
    end
  end

  // PENDING: set by a staging write while running, cleared by the boundary load; write wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (!running) begin
      pend_q <= 1'b0;
    end else if (stage_wr) begin
      pend_q <= 1'b1;
    end else if (load) begin
      pend_q <= 1'b0;
    end
  end

  // Stage 0: raw compare against the active duty values
  assign raw_p0[0] = (cnt_q < duty0_a);
  assign raw_p0[1] = (cnt_q < duty1_a);

  // Stage 1: registered outputs; a disabled channel rests at its polarity level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p1 <= 2'b00;
    end else begin
      pwm_p1[0] <= ctrl_q[0] ? (raw_p0[0] ^ ctrl_q[2]) : ctrl_q[2];
      pwm_p1[1] <= ctrl_q[1] ? (raw_p0[1] ^ ctrl_q[3]) : ctrl_q[3];
    end
  end

  assign pwm_out = pwm_p1;

  // Combinational read path; staging values are returned for period/duty.
  always_comb begin
    data_rd_o = 8'h00;
    case (reg_addr)
      A_CTRL:     data_rd_o = {4'h0, ctrl_q};
      A_PRESCALE: data_rd_o = prescale_q;
      A_PERIOD:   data_rd_o = period_s;
      A_DUTY0:    data_rd_o = duty0_s;
      A_DUTY1:    data_rd_o = duty1_s;
      A_STATUS:   data_rd_o = {7'h00, pend_q};
      A_ID:       data_rd_o = ID_VALUE;
      A_COUNT:    data_rd_o = cnt_q;
      default:    data_rd_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_pwm_regbank.sv
// Self-checking bench for pwm_regbank: register-map vectors from a table,
// then directed sequences for PWM shape, double buffering, polarity,
// prescaling, held strobes, load/write collision and mid-run reset.
module tb_pwm_regbank;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr_reg;
  logic [7:0] data_wr;
  logic       wr_en;
  logic [7:0] data_rd_o;
  logic [1:0] pwm_out;

  int n_chk;
  int n_err;

  pwm_regbank #(.ID_VALUE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_reg  (addr_reg),
    .data_wr   (data_wr),
    .wr_en     (wr_en),
    .data_rd_o (data_rd_o),
    .pwm_out   (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_reg = a;
    data_wr  = d;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    addr_reg = a;
    #1;
    v = data_rd_o;
  endtask

  // Waits for a rising edge on one channel, then times the high and low phases.
  task automatic measure(input int ch, output int hi, output int lo);
    logic prev, cur;
    bit   rise;
    int   guard;
    hi = 0;
    lo = 0;
    guard = 0;
    rise = 1'b0;
    @(negedge clk);
    prev = pwm_out[ch];
    cur  = prev;
    while (!rise && guard < 2000) begin
      @(negedge clk);
      cur  = pwm_out[ch];
      rise = !prev && cur;
      prev = cur;
      guard++;
    end
    if (!rise) return;
    while (cur && guard < 3000) begin
      hi++;
      @(negedge clk);
      cur = pwm_out[ch];
      guard++;
    end
    while (!cur && guard < 4000) begin
      lo++;
      @(negedge clk);
      cur = pwm_out[ch];
      guard++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int hi, lo, cnt_hi, guard;
    bit found;

    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    addr_reg = 8'h00;
    data_wr  = 8'h00;
    wr_en    = 1'b0;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h01, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h02, 8'hFF};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'h03, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h04, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h05, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h06, 8'hA5};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h07, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'h7F, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h86, 8'hA5};
    vecs[10] = '{1'b1, 8'h00, 8'hF0, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 8'h06, 8'h12, 8'h06, 8'hA5};
    vecs[12] = '{1'b1, 8'h01, 8'h5A, 8'h01, 8'h5A};
    vecs[13] = '{1'b1, 8'h81, 8'h07, 8'h01, 8'h07};
    vecs[14] = '{1'b1, 8'h04, 8'hC3, 8'h04, 8'hC3};
    vecs[15] = '{1'b1, 8'h20, 8'h77, 8'h20, 8'h00};
    vecs[16] = '{1'b1, 8'h05, 8'hFF, 8'h05, 8'h00};
    vecs[17] = '{1'b1, 8'h07, 8'h33, 8'h07, 8'h00};
    vecs[18] = '{1'b1, 8'h01, 8'h00, 8'h01, 8'h00};
    vecs[19] = '{1'b1, 8'h04, 8'h00, 8'h04, 8'h00};

    // Reset state
    #1;
    chk("pwm_in_reset", pwm_out, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("pwm_after_reset", pwm_out, 2'b00);

    // Register map vectors
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, v);
      chk($sformatf("vec%0d_rd_%02h", i, vecs[i].raddr), v, vecs[i].exp);
    end

    // Basic PWM: period 10 clocks, 3 high
    wr(8'h02, 8'd9);
    wr(8'h03, 8'd3);
    wr(8'h01, 8'd0);
    wr(8'h00, 8'h01);
    measure(0, hi, lo);
    chk("basic_high", hi, 3);
    chk("basic_low", lo, 7);
    chk("basic_ch1_idle", pwm_out[1], 0);

    // Double buffering: mid-period duty change waits for the wrap
    wr(8'h03, 8'd7);
    rd(8'h05, v);
    chk("dbuf_pending", v, 8'h01);
    rd(8'h03, v);
    chk("dbuf_staging", v, 8'd7);
    measure(0, hi, lo);
    chk("dbuf_high", hi, 7);
    chk("dbuf_low", lo, 3);
    rd(8'h05, v);
    chk("dbuf_pending_clr", v, 8'h00);

    // Polarity and extremes
    wr(8'h03, 8'd0);
    wr(8'h00, 8'h0F);
    repeat (25) @(negedge clk);
    cnt_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_out[0]) cnt_hi++;
    end
    chk("inv_duty0_const1", cnt_hi, 20);
    wr(8'h04, 8'hFF);
    repeat (25) @(negedge clk);
    cnt_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_out[1]) cnt_hi++;
    end
    chk("inv_duty1_full_const0", cnt_hi, 0);
    wr(8'h00, 8'h0C);
    repeat (2) @(negedge clk);
    chk("disabled_rest_pol", pwm_out, 2'b11);
    rd(8'h07, v);
    chk("idle_count_zero", v, 8'h00);

    // Prescaler: COUNT advances every 4 clocks, period of 5 ticks
    wr(8'h01, 8'd3);
    wr(8'h02, 8'd4);
    wr(8'h03, 8'd2);
    wr(8'h04, 8'd0);
    wr(8'h00, 8'h01);
    addr_reg = 8'h07;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("psc_count_clk%0d", j), data_rd_o, (j / 4) % 5);
    end
    measure(0, hi, lo);
    chk("psc_high", hi, 8);
    chk("psc_low", lo, 12);

    // Held strobe: 20 identical writes give one clean value
    wr(8'h01, 8'd0);
    wr(8'h02, 8'd9);
    @(negedge clk);
    addr_reg = 8'h03;
    data_wr  = 8'd5;
    wr_en    = 1'b1;
    repeat (20) @(negedge clk);
    wr_en    = 1'b0;
    rd(8'h03, v);
    chk("held_staging", v, 8'd5);
    measure(0, hi, lo);
    chk("held_high_a", hi, 5);
    chk("held_low_a", lo, 5);
    measure(0, hi, lo);
    chk("held_high_b", hi, 5);
    chk("held_low_b", lo, 5);

    // Collision: PERIOD write on the exact wrap cycle
    addr_reg = 8'h07;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 50) begin
      @(negedge clk);
      #1;
      found = (data_rd_o == 8'd9);
      guard++;
    end
    chk("coll_found_wrap", found, 1);
    addr_reg = 8'h02;
    data_wr  = 8'd6;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
    addr_reg = 8'h07;
    #1;
    chk("coll_wrapped", data_rd_o, 0);
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      case (j)
        1:       addr_reg = 8'h05;
        2:       addr_reg = 8'h02;
        11:      addr_reg = 8'h05;
        default: addr_reg = 8'h07;
      endcase
      #1;
      case (j)
        1:  chk("coll_pending", data_rd_o, 8'h01);
        2:  chk("coll_staging_new", data_rd_o, 8'd6);
        9:  chk("coll_old_period_runs", data_rd_o, 8'd9);
        10: chk("coll_old_period_wrap", data_rd_o, 8'd0);
        11: chk("coll_pending_clr", data_rd_o, 8'h00);
        16: chk("coll_new_period_top", data_rd_o, 8'd6);
        17: chk("coll_new_period_wrap", data_rd_o, 8'd0);
        default: ;
      endcase
    end

    // Reset mid-period drops everything at once
    wr(8'h00, 8'h0D);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pwm", pwm_out, 2'b00);
    rd(8'h00, v);
    chk("midrst_ctrl", v, 8'h00);
    rd(8'h02, v);
    chk("midrst_period", v, 8'hFF);
    rd(8'h07, v);
    chk("midrst_count", v, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_pwm", pwm_out, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
